pll_supervisor: RTL and testbench
=================================

# pll_supervisor

Parametrised PLL bring-up and lock supervisor. Runs on the PLL reference clock. Drives the PLL reset and qualifies the asynchronous `locked` indication. Releases NUM_CH downstream domain resets in a staggered sequence, and re-runs bring-up when lock is lost (with retry limit, timeout and fail reporting). Sits between board reset and each `pll` instance, ahead of the hashing cores.

## Interface
Parameters:
- NUM_CH, 1: number of downstream domain resets.
- RST_PULSE, 16: cycles `pll_rst` is held per attempt (≥1).
- LOCK_TIMEOUT, 250000: cycles allowed in WAIT_LOCK per attempt (10 ms at 25 MHz).
- DEBOUNCE, 4: consecutive synchronised cycles required to accept lock or lock loss (≥1).
- STAGGER, 8: cycles between successive `ch_rst` releases (≥1).
- MAX_RETRY, 3: failed attempts allowed before FAIL (≥1).

Ports:
- refclk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- pll_locked  in  1  PLL lock; asynchronous.
- restart  in  1  one-cycle soft restart request.
- pll_rst  out  1  PLL reset, active-high.
- ch_rst  out  NUM_CH  per-domain resets, active-high, refclk domain. Each consumer synchronises its own copy.
- ready  out  1  all channels released, lock stable.
- fail  out  1  retries exhausted.
- state  out  3  current FSM state encoding.
- relock_cnt  out  8  saturating count of lock-loss events.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lk_s`. A debounce counter counts consecutive equal samples of `lk_s`.
- States:
  - RESET=0: `pll_rst`=1 and all `ch_rst`=1 for RST_PULSE cycles, then go to WAIT_LOCK.
  - WAIT_LOCK=1: `pll_rst`=0. The timeout counter starts at 0 on entry.
    - `lk_s`=1 for DEBOUNCE consecutive cycles: go to RELEASE.
    - Any 0 sample restarts the debounce count.
    - Timeout counter reaches LOCK_TIMEOUT-1: retry+1. If retry==MAX_RETRY go to FAIL, else go to RESET.
  - RELEASE=2: `ch_rst[i]` falls i*STAGGER cycles after entry. The cycle after `ch_rst[NUM_CH-1]` falls, go to RUN and clear retry.
    - `lk_s`=0 for DEBOUNCE cycles here counts as lock loss, handled as in RUN.
  - RUN=3: `ready`=1. `lk_s`=0 for DEBOUNCE consecutive cycles is a lock loss: all `ch_rst`=1 and `ready`=0 in the next cycle, relock_cnt+1, go to RESET.
  - FAIL=4: `fail`=1, `pll_rst`=1, all `ch_rst`=1. Exits only via `rst` or `restart`.
- `restart`: accepted in any state. Goes to RESET and clears retry and `fail`. relock_cnt is not incremented.
- Simultaneous events:
  - `restart` and lock loss in the same cycle: `restart` wins, no increment.
  - `rst` overrides everything.
- relock_cnt saturates at 255 and is cleared only by `rst`.

## Timing
- Reset values: `pll_rst`=1, `ch_rst`=all 1, `ready`=0, `fail`=0, `state`=RESET, `relock_cnt`=0. All counters and retry are 0.
- `rst` asserted mid-operation: in the next cycle all outputs return to their reset values, including a mid-RELEASE sequence.
- Lock acceptance latency: 2 synchroniser cycles + DEBOUNCE cycles from the `pll_locked` edge to RELEASE entry.
- `ch_rst[0]` falls in the first RELEASE cycle. `ready` rises (NUM_CH-1)*STAGGER+1 cycles after RELEASE entry.
- Lock-loss reaction: 2 + DEBOUNCE cycles from the `pll_locked` fall to `ch_rst` asserted.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- PLL_SUPERVISOR_STATS_EN defined: relock_cnt counter is present as specified.
- Not defined: relock_cnt is tied to 0 and no counter flops are built.

## Structure
- pll_supervisor_pkg holds:
  - the state enum, with values as listed under Operation;
  - the relock_cnt width constant (8);
  - a clog2-based counter width helper.
- Sub-module sync_2ff is a generic 2-flop synchroniser, reused for `pll_locked`.
- Counter sizing:
  - one shared phase counter, sized for max(RST_PULSE, LOCK_TIMEOUT, (NUM_CH-1)*STAGGER+1);
  - a separate debounce counter.

## Test plan
Parameters for all scenarios: NUM_CH=3, RST_PULSE=4, STAGGER=2, DEBOUNCE=3, LOCK_TIMEOUT=20, MAX_RETRY=2.
- Normal bring-up: release `rst`, raise `pll_locked` 6 cycles later -> `pll_rst` falls 4 cycles after `rst` release; `ch_rst` falls one bit at a time at RELEASE+0, +2, +4; `ready`=1 at RELEASE+5.
- Lock glitch: in WAIT_LOCK, `pll_locked` high 2 cycles, low 1, then high -> RELEASE is entered only after 3 consecutive synchronised high samples; no early release.
- Timeout and fail: hold `pll_locked`=0 -> two RESET/WAIT_LOCK attempts of 20 cycles each, then `fail`=1 with `pll_rst`=1; `restart` pulse -> `fail`=0, `state`=RESET.
- Lock loss in RUN: drop `pll_locked` for 3+ cycles -> all `ch_rst`=1 and `ready`=0 exactly 5 cycles after the drop; relock_cnt=1; full bring-up repeats.
- Mid-operation reset: assert `rst` at RELEASE+1 -> next cycle all outputs at reset values and relock_cnt=0.
- Stats off: build without PLL_SUPERVISOR_STATS_EN and repeat the lock-loss scenario -> relock_cnt stays 0.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL bring-up / lock supervisor.
package pll_supervisor_pkg;

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   localparam int RELOCK_W = 8;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// Generic two-flop synchroniser for slow asynchronous level signals.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset sequencing, lock qualification and staggered domain-reset release.
// Optional relock statistics counter enabled by defining PLL_SUPERVISOR_STATS_EN.
module pll_supervisor
   import pll_supervisor_pkg::*;
#(
   parameter int NUM_CH       = 1,
   parameter int RST_PULSE    = 16,
   parameter int LOCK_TIMEOUT = 250000,
   parameter int DEBOUNCE     = 4,
   parameter int STAGGER      = 8,
   parameter int MAX_RETRY    = 3
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                pll_locked,
   input  logic                restart,
   output logic                pll_rst,
   output logic [NUM_CH-1:0]   ch_rst,
   output logic                ready,
   output logic                fail,
   output logic [2:0]          state,
   output logic [RELOCK_W-1:0] relock_cnt
);

   localparam logic [2:0] S_RESET     = ST_RESET;
   localparam logic [2:0] S_WAIT_LOCK = ST_WAIT_LOCK;
   localparam logic [2:0] S_RELEASE   = ST_RELEASE;
   localparam logic [2:0] S_RUN       = ST_RUN;
   localparam logic [2:0] S_FAIL      = ST_FAIL;

   localparam int REL_LEN = (NUM_CH - 1) * STAGGER + 1;
   localparam int PH_N0   = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
   localparam int PH_N    = (PH_N0 > REL_LEN) ? PH_N0 : REL_LEN;
   localparam int PH_W    = cnt_w(PH_N);
   localparam int DEB_W   = cnt_w(DEBOUNCE + 1);
   localparam int RT_W    = cnt_w(MAX_RETRY + 1);

   localparam logic [PH_W-1:0]  PH_RST_END = PH_W'(RST_PULSE - 1);
   localparam logic [PH_W-1:0]  PH_TO_END  = PH_W'(LOCK_TIMEOUT - 1);
   localparam logic [PH_W-1:0]  PH_REL_END = PH_W'(REL_LEN - 1);
   localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEBOUNCE);
   localparam logic [RT_W-1:0]  RT_LAST    = RT_W'(MAX_RETRY - 1);

   logic lk_s;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk_s)
   );

   // Debounce: deb_cur is the run length including the current lk_s sample.
   logic             deb_val_q, deb_val_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [DEB_W-1:0] deb_cur;
   logic             stable_hi, stable_lo;

   always_comb begin
      deb_cur = DEB_W'(1);
      if (lk_s == deb_val_q) begin
         deb_cur = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);
      end
      deb_val_d = lk_s;
      deb_cnt_d = deb_cur;
      stable_hi = lk_s && (deb_cur == DEB_MAX);
      stable_lo = !lk_s && (deb_cur == DEB_MAX);
   end

   logic [2:0]      state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [RT_W-1:0] retry_q, retry_d;
   logic            lock_lost;

   assign lock_lost = ((state_q == S_RELEASE) || (state_q == S_RUN)) && stable_lo;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q + PH_W'(1);
      retry_d = retry_q;
      if (restart) begin
         state_d = S_RESET;
         phase_d = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            S_RESET: begin
               if (phase_q == PH_RST_END) begin
                  state_d = S_WAIT_LOCK;
                  phase_d = '0;
               end
            end
            S_WAIT_LOCK: begin
               if (stable_hi) begin
                  state_d = S_RELEASE;
                  phase_d = '0;
               end else if (phase_q == PH_TO_END) begin
                  phase_d = '0;
                  retry_d = retry_q + RT_W'(1);
                  state_d = (retry_q >= RT_LAST) ? S_FAIL : S_RESET;
               end
            end
            S_RELEASE: begin
               if (lock_lost) begin
                  state_d = S_RESET;
                  phase_d = '0;
               end else if (phase_q == PH_REL_END) begin
                  state_d = S_RUN;
                  phase_d = '0;
                  retry_d = '0;
               end
            end
            S_RUN: begin
               phase_d = '0;
               if (lock_lost) state_d = S_RESET;
            end
            S_FAIL: begin
               phase_d = '0;
            end
            default: begin
               state_d = S_RESET;
               phase_d = '0;
            end
         endcase
      end
   end

   // Channel i stays in reset while the RELEASE phase is below i*STAGGER.
   logic [NUM_CH-1:0] rel_hold;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_rel
      if (g == 0) begin : g_first
         assign rel_hold[g] = 1'b0;
      end else begin : g_rest
         assign rel_hold[g] = (phase_d < PH_W'(g * STAGGER));
      end
   end

   logic              pll_rst_q, pll_rst_d;
   logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
   logic              ready_q, ready_d;
   logic              fail_q, fail_d;

   always_comb begin
      pll_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
      ready_d   = (state_d == S_RUN);
      fail_d    = (state_d == S_FAIL);
      ch_rst_d  = '1;
      if (state_d == S_RELEASE) ch_rst_d = rel_hold;
      else if (state_d == S_RUN) ch_rst_d = '0;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= S_RESET;
         phase_q   <= '0;
         retry_q   <= '0;
         deb_val_q <= 1'b0;
         deb_cnt_q <= '0;
         pll_rst_q <= 1'b1;
         ch_rst_q  <= '1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         retry_q   <= retry_d;
         deb_val_q <= deb_val_d;
         deb_cnt_q <= deb_cnt_d;
         pll_rst_q <= pll_rst_d;
         ch_rst_q  <= ch_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   assign pll_rst = pll_rst_q;
   assign ch_rst  = ch_rst_q;
   assign ready   = ready_q;
   assign fail    = fail_q;
   assign state   = state_q;

`ifdef PLL_SUPERVISOR_STATS_EN
   // A restart in the same cycle as a lock loss is not counted.
   logic [RELOCK_W-1:0] relock_q, relock_d;

   always_comb begin
      relock_d = relock_q;
      if (!restart && lock_lost && (relock_q != '1)) relock_d = relock_q + RELOCK_W'(1);
   end

   always_ff @(posedge refclk) begin
      if (rst) relock_q <= '0;
      else     relock_q <= relock_d;
   end

   assign relock_cnt = relock_q;
`else
   assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: bring-up, glitch rejection, timeout/fail, lock loss, reset.
module tb_pll_supervisor;

   localparam int NUM_CH = 3;

`ifdef PLL_SUPERVISOR_STATS_EN
   localparam logic [7:0] RL1 = 8'd1;
`else
   localparam logic [7:0] RL1 = 8'd0;
`endif

   logic              refclk = 1'b0;
   logic              rst = 1'b1;
   logic              pll_locked = 1'b0;
   logic              restart = 1'b0;
   logic              pll_rst;
   logic [NUM_CH-1:0] ch_rst;
   logic              ready;
   logic              fail;
   logic [2:0]        state;
   logic [7:0]        relock_cnt;

   int errors = 0;
   int checks = 0;

   pll_supervisor #(
      .NUM_CH       (NUM_CH),
      .RST_PULSE    (4),
      .LOCK_TIMEOUT (20),
      .DEBOUNCE     (3),
      .STAGGER      (2),
      .MAX_RETRY    (2)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .restart    (restart),
      .pll_rst    (pll_rst),
      .ch_rst     (ch_rst),
      .ready      (ready),
      .fail       (fail),
      .state      (state),
      .relock_cnt (relock_cnt)
   );

   always #5 refclk = ~refclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // Leaves the bench 1 time unit after the last edge that sampled rst=1 (edge P0).
   task automatic do_reset();
      rst = 1'b1;
      pll_locked = 1'b0;
      restart = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // Lock raised after P6 gives RELEASE at P11 and RUN at P16; returns after P16.
   task automatic reach_run();
      do_reset();
      repeat (6) tick();
      pll_locked = 1'b1;
      repeat (10) tick();
   endtask

   // Outputs packed as {pll_rst, ch_rst, ready, fail, state}.
   task automatic test_reset();
      do_reset();
      checks++;
      if ({pll_rst, ch_rst, ready, fail, state} !== {1'b1, 3'b111, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {pll_rst, ch_rst, ready, fail, state}, {1'b1, 3'b111, 1'b0, 1'b0, 3'd0});
      end
      checks++;
      if (relock_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_relock: got %0d expected 0", relock_cnt);
      end
   endtask

   task automatic test_bringup();
      logic [2:0] exp_ch [0:5];
      exp_ch[0] = 3'b110; exp_ch[1] = 3'b110; exp_ch[2] = 3'b100;
      exp_ch[3] = 3'b100; exp_ch[4] = 3'b000; exp_ch[5] = 3'b000;
      do_reset();
      repeat (3) tick();
      checks++;
      if ({pll_rst, state} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL bringup_p3: got %b expected %b", {pll_rst, state}, {1'b1, 3'd0});
      end
      tick();
      checks++;
      if ({pll_rst, ch_rst, state} !== {1'b0, 3'b111, 3'd1}) begin
         errors++;
         $display("FAIL bringup_p4: got %b expected %b", {pll_rst, ch_rst, state}, {1'b0, 3'b111, 3'd1});
      end
      repeat (2) tick();
      pll_locked = 1'b1;
      repeat (4) tick();
      checks++;
      if (state !== 3'd1) begin
         errors++;
         $display("FAIL bringup_p10_wait: got %0d expected 1", state);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if ({ch_rst, ready, state} !== {exp_ch[k], (k == 5), ((k == 5) ? 3'd3 : 3'd2)}) begin
            errors++;
            $display("FAIL bringup_release_%0d: got %b expected %b", k,
                     {ch_rst, ready, state}, {exp_ch[k], (k == 5), ((k == 5) ? 3'd3 : 3'd2)});
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      repeat (6) tick();
      pll_locked = 1'b1;
      repeat (2) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      repeat (2) tick();
      checks++;
      if ({ch_rst, state} !== {3'b111, 3'd1}) begin
         errors++;
         $display("FAIL glitch_p11: got %b expected %b", {ch_rst, state}, {3'b111, 3'd1});
      end
      repeat (2) tick();
      checks++;
      if ({ch_rst, state} !== {3'b111, 3'd1}) begin
         errors++;
         $display("FAIL glitch_p13: got %b expected %b", {ch_rst, state}, {3'b111, 3'd1});
      end
      tick();
      checks++;
      if ({ch_rst, state} !== {3'b110, 3'd2}) begin
         errors++;
         $display("FAIL glitch_p14: got %b expected %b", {ch_rst, state}, {3'b110, 3'd2});
      end
   endtask

   task automatic test_timeout_fail();
      do_reset();
      repeat (23) tick();
      checks++;
      if ({pll_rst, state} !== {1'b0, 3'd1}) begin
         errors++;
         $display("FAIL timeout1_last_wait: got %b expected %b", {pll_rst, state}, {1'b0, 3'd1});
      end
      tick();
      checks++;
      if ({pll_rst, fail, state} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL timeout1_retry: got %b expected %b", {pll_rst, fail, state}, {1'b1, 1'b0, 3'd0});
      end
      repeat (23) tick();
      checks++;
      if ({fail, state} !== {1'b0, 3'd1}) begin
         errors++;
         $display("FAIL timeout2_last_wait: got %b expected %b", {fail, state}, {1'b0, 3'd1});
      end
      tick();
      checks++;
      if ({pll_rst, ch_rst, ready, fail, state} !== {1'b1, 3'b111, 1'b0, 1'b1, 3'd4}) begin
         errors++;
         $display("FAIL fail_entry: got %b expected %b",
                  {pll_rst, ch_rst, ready, fail, state}, {1'b1, 3'b111, 1'b0, 1'b1, 3'd4});
      end
      repeat (4) tick();
      checks++;
      if ({fail, state} !== {1'b1, 3'd4}) begin
         errors++;
         $display("FAIL fail_hold: got %b expected %b", {fail, state}, {1'b1, 3'd4});
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if ({pll_rst, fail, state} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL restart_exit: got %b expected %b", {pll_rst, fail, state}, {1'b1, 1'b0, 3'd0});
      end
      repeat (24) tick();
      checks++;
      if ({fail, state} !== {1'b0, 3'd0}) begin
         errors++;
         $display("FAIL restart_retry_cleared: got %b expected %b", {fail, state}, {1'b0, 3'd0});
      end
   endtask

   task automatic test_lock_loss();
      reach_run();
      checks++;
      if ({ch_rst, ready, state, relock_cnt} !== {3'b000, 1'b1, 3'd3, 8'd0}) begin
         errors++;
         $display("FAIL loss_run_before: got %h expected %h",
                  {ch_rst, ready, state, relock_cnt}, {3'b000, 1'b1, 3'd3, 8'd0});
      end
      pll_locked = 1'b0;
      repeat (4) tick();
      checks++;
      if ({ch_rst, ready, state} !== {3'b000, 1'b1, 3'd3}) begin
         errors++;
         $display("FAIL loss_drop_plus4: got %b expected %b", {ch_rst, ready, state}, {3'b000, 1'b1, 3'd3});
      end
      tick();
      checks++;
      if ({pll_rst, ch_rst, ready, state} !== {1'b1, 3'b111, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL loss_drop_plus5: got %b expected %b",
                  {pll_rst, ch_rst, ready, state}, {1'b1, 3'b111, 1'b0, 3'd0});
      end
      checks++;
      if (relock_cnt !== RL1) begin
         errors++;
         $display("FAIL loss_relock_cnt: got %0d expected %0d", relock_cnt, RL1);
      end
      pll_locked = 1'b1;
      repeat (5) tick();
      checks++;
      if ({ch_rst, state} !== {3'b110, 3'd2}) begin
         errors++;
         $display("FAIL loss_rebring_release: got %b expected %b", {ch_rst, state}, {3'b110, 3'd2});
      end
      repeat (5) tick();
      checks++;
      if ({ch_rst, ready, state} !== {3'b000, 1'b1, 3'd3}) begin
         errors++;
         $display("FAIL loss_rebring_run: got %b expected %b", {ch_rst, ready, state}, {3'b000, 1'b1, 3'd3});
      end
      pll_locked = 1'b0;
      repeat (4) tick();
      checks++;
      if (state !== 3'd3) begin
         errors++;
         $display("FAIL collide_before: got %0d expected 3", state);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if ({state, relock_cnt} !== {3'd0, RL1}) begin
         errors++;
         $display("FAIL collide_restart_wins: got %h expected %h", {state, relock_cnt}, {3'd0, RL1});
      end
   endtask

   task automatic test_mid_reset();
      reach_run();
      pll_locked = 1'b0;
      repeat (5) tick();
      pll_locked = 1'b1;
      repeat (6) tick();
      checks++;
      if ({ch_rst, state, relock_cnt} !== {3'b110, 3'd2, RL1}) begin
         errors++;
         $display("FAIL midrst_release_plus1: got %h expected %h",
                  {ch_rst, state, relock_cnt}, {3'b110, 3'd2, RL1});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({pll_rst, ch_rst, ready, fail, state} !== {1'b1, 3'b111, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL midrst_outputs: got %b expected %b",
                  {pll_rst, ch_rst, ready, fail, state}, {1'b1, 3'b111, 1'b0, 1'b0, 3'd0});
      end
      checks++;
      if (relock_cnt !== 8'd0) begin
         errors++;
         $display("FAIL midrst_relock: got %0d expected 0", relock_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_glitch();
      test_timeout_fail();
      test_lock_loss();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
